// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared state type, width helper and limits for the ser_piso serializer
package ser_pkg;

  localparam int SER_MAX_WIDTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  function automatic int ser_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ser_piso_if.sv
// rtl/ser_piso_if.sv - word load handshake between the upstream producer and ser_piso
interface ser_piso_if #(
  parameter int WIDTH = 8
);

  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);

endinterface

// File: rtl/ser_bit_counter.sv
// rtl/ser_bit_counter.sv - loadable down-counter tracking the bits left in the current frame
module ser_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last,
  output logic             penult
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at zero; the FSM leaves SHIFT before a wrap could matter.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last   = (cnt_q == '0);
  assign penult = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ser_piso.sv
// rtl/ser_piso.sv - parallel-in/serial-out word serializer; SER_PIPO_PARITY_EN appends an even-parity bit
module ser_piso
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  ser_piso_if.slave  ld,
  output logic       d_out,
  output logic       d_valid,
  output logic       frame_start,
  output logic       busy
);

`ifdef SER_PIPO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = ser_cnt_w(WIDTH);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             d_out_q, d_out_d;
  logic             d_valid_q, d_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             last;
`ifdef SER_PIPO_PARITY_EN
  logic             penult;
  logic             parity_q, parity_d;
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign ld.load_ready = (state_q == IDLE) || last;
  assign accept        = ld.load_valid && ld.load_ready;

  ser_bit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (CNT_W'(FRAME_LEN - 1)),
    .dec      ((state_q == SHIFT) && !accept),
    .last     (last),
`ifdef SER_PIPO_PARITY_EN
    .penult   (penult)
`else
    .penult   ()
`endif
  );

  // The first bit goes out on the accept edge, so the register holds only the rest.
  always_comb begin
    state_d       = IDLE;
    shreg_d       = shreg_q;
    d_out_d       = 1'b0;
    d_valid_d     = 1'b0;
    frame_start_d = 1'b0;
    busy_d        = 1'b0;
    if (accept) begin
      state_d       = SHIFT;
      shreg_d       = drop_head(ld.load_data);
      d_out_d       = head_bit(ld.load_data);
      d_valid_d     = 1'b1;
      frame_start_d = 1'b1;
      busy_d        = 1'b1;
    end else if ((state_q == SHIFT) && !last) begin
      state_d   = SHIFT;
      d_valid_d = 1'b1;
      busy_d    = 1'b1;
`ifdef SER_PIPO_PARITY_EN
      if (penult) d_out_d = parity_q;
      else
`endif
      begin
        d_out_d = head_bit(shreg_q);
        shreg_d = drop_head(shreg_q);
      end
    end
  end

`ifdef SER_PIPO_PARITY_EN
  assign parity_d = accept ? (^ld.load_data) : parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      d_out_q       <= 1'b0;
      d_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      d_out_q       <= d_out_d;
      d_valid_q     <= d_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  assign d_out       = d_out_q;
  assign d_valid     = d_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule

// File: doc/ser_piso.md
# ser_piso

Parallel-in/serial-out stage that sits directly upstream of the three-flop `d`→Q1→Q2→Q3 shift chain and produces its `d` bit stream. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per `clk` rising edge, with a per-bit valid qualifier and a frame-start marker. Back-to-back words stream with no idle gap, so the downstream chain sees a continuous bit sequence.

## Interface
- `WIDTH`, default 8: bits per word; legal range 1..32.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `load_valid` input, 1 bit: upstream word is present on `load_data`.
- `load_data` input, WIDTH bits: word to serialize; sampled only on an accept.
- `load_ready` output, 1 bit: block can accept a word this cycle.
- `d_out` output, 1 bit: serial bit; drives the downstream `d`.
- `d_valid` output, 1 bit: `d_out` carries a real bit this cycle.
- `frame_start` output, 1 bit: high with the first bit of each word.
- `busy` output, 1 bit: a word is being shifted.

## Operation
- States: IDLE, SHIFT.
- Accept: `load_valid && load_ready` at a rising edge. Load the shift register with `load_data` and set the bit counter to FRAME_LEN-1. FRAME_LEN is WIDTH, or WIDTH+1 with parity.
- IDLE→SHIFT on accept. In SHIFT, each edge presents the next bit and decrements the counter.
- When the counter is 0, the current bit is the last one. If an accept occurs that edge, stay in SHIFT and reload. Otherwise go to IDLE.
- `load_ready` is combinational from registered state: high in IDLE, or in SHIFT when the counter is 0. It never depends on `load_valid`.
- `load_valid` while `load_ready` is low is ignored. The held word is not overwritten, and upstream keeps `load_data` stable until accepted.
- `d_out`, `d_valid`, `frame_start` and `busy` are registered.
- When `d_valid` is low, `d_out` is 0.
- Bit order follows `MSB_FIRST`. The shift direction is chosen at elaboration; there is no runtime mux.
- Counter width is `$clog2(WIDTH+1)`. Decrement never wraps below 0; state leaves SHIFT before that.
- Reset, any time, including mid-word:
  - state IDLE, counter 0, shift register 0;
  - `d_out`=0, `d_valid`=0, `frame_start`=0, `busy`=0, `load_ready`=1;
  - a partially sent word is discarded and not resumed.

## Timing
- Accept at edge N: first bit on `d_out` with `d_valid`=1 and `frame_start`=1 after edge N. The last data bit is valid after edge N+FRAME_LEN-1.
- Latency from accept to first bit: 1 cycle.
- Throughput: one word per FRAME_LEN cycles when `load_valid` is held high. `d_valid` stays continuously high across word boundaries.
- Idle return: if there is no accept on the last-bit edge, `d_valid` and `busy` drop after the following edge.
- `frame_start` is a one-cycle pulse per word.
- WIDTH=1 without parity: the counter is always 0, `load_ready` stays high, and every accept yields one bit with `frame_start`=1.

## Configuration
- Macro: `SER_PIPO_PARITY_EN`.
- Defined: an even-parity bit follows the last data bit (FRAME_LEN=WIDTH+1). Parity is the XOR of `load_data`, computed at accept and stored. `load_ready` reasserts during the parity bit, not the last data bit.
- Undefined: no parity logic or storage; FRAME_LEN=WIDTH.

## Structure
- Shared package `ser_pkg`:
  - state enum `ser_state_t` {IDLE, SHIFT};
  - localparam function `ser_cnt_w(width)` returning `$clog2(width+1)`;
  - `SER_MAX_WIDTH`=32.
- One sub-module, `ser_bit_counter`. It is a loadable down-counter with load/decrement inputs, async active-low reset and a `last` output. The FSM and shift register stay in `ser_piso`.

## Test plan
- WIDTH=8, MSB_FIRST=1, accept 0xA5 at edge N → `d_out` 1,0,1,0,0,1,0,1 on cycles N+1..N+8, `frame_start` only at N+1, `d_valid` low at N+9.
- Same, MSB_FIRST=0 → `d_out` 1,0,1,0,0,1,0,1 reversed: 1,0,1,0,0,1,0,1 from bit 0 is 1,0,1,0,0,1,0,1. Also run 0x01 → 1,0,0,0,0,0,0,0.
- Back-to-back: 0xA5 then 0x3C with `load_valid` held → 16 contiguous valid bits, `frame_start` at N+1 and N+9, `load_ready` high only at N and N+8.
- `load_valid` pulsed with 0xFF at N+3 during 0xA5 → ignored; output still 0xA5, no frame for 0xFF.
- `rst_n` low at N+4 (asynchronous, mid-clock) → all outputs 0 immediately and `load_ready`=1. A new 0x3C after release serializes cleanly.
- With `SER_PIPO_PARITY_EN`: 0xA5 → 9 bits ending in parity 0; 0x07 → parity 1; `load_ready` high on the parity cycle.
